bitwise_reduce_acc: RTL

BITWISE_REDUCE_ACC -- requirements
Module: bitwise_reduce_acc

---
 rtl/bitwise_pkg.sv | 20 ++
 rtl/logic_op_cell.sv | 25 ++
 rtl/bitwise_reduce_acc.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bitwise_pkg.sv
// Shared encodings for the bitwise reduce accumulator: operation select and FSM state.
package bitwise_pkg;

    // Operation select; NAND folds as AND and inverts only at the output.
    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    // Packet FSM: IDLE waits for a first beat, ACC folds further beats,
    // DONE presents the result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/logic_op_cell.sv
// Lane-wise combinational logic function shared by beat evaluation and folding.
module logic_op_cell
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // NAND reduces as AND; the inversion is applied once on the final result.
    always_comb begin
        y = a & b;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = a & b;
            default: y = a & b;
        endcase
    end

endmodule

// File: rtl/bitwise_reduce_acc.sv
// Packetised bitwise reducer: folds f(in_a, in_b) over the beats of a packet,
// counts beats (saturating, with overflow flag) and offers one result per packet.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready on the
// same side. in_ready is high in IDLE/ACC (low in DONE and during reset); out_valid
// is high only in DONE, and the result fields stay frozen until out_ready.
module bitwise_reduce_acc
    import bitwise_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    op_e              eff_op;
    logic [WIDTH-1:0] beat_v;
    logic [WIDTH-1:0] fold_v;
    logic             accept;
    logic             out_fire;

    // op is only honoured on the first beat; later beats reuse the latched op.
    assign eff_op   = (state_q == ST_IDLE) ? op_e'(op) : op_q;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    logic_op_cell #(.WIDTH(WIDTH)) u_beat_cell (
        .op (eff_op),
        .a  (in_a),
        .b  (in_b),
        .y  (beat_v)
    );

    logic_op_cell #(.WIDTH(WIDTH)) u_fold_cell (
        .op (eff_op),
        .a  (acc_q),
        .b  (beat_v),
        .y  (fold_v)
    );

    // State register: every flop of the block lives here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic for the packet FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = in_last ? ST_DONE : ST_ACC;
            ST_ACC:  if (accept && in_last) state_d = ST_DONE;
            ST_DONE: if (out_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on first beat, fold on later beats, clear on result handshake.
    always_comb begin
        op_d    = op_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (state_q == ST_DONE) begin
            if (out_fire) begin
                op_d    = OP_AND;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
            end
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                op_d    = op_e'(op);
                acc_d   = beat_v;
                count_d = ONE_CNT;
                ovf_d   = 1'b0;
            end else begin
                acc_d = fold_v;
                if (count_q == MAX_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + ONE_CNT;
                end
            end
        end
    end

    // Outputs decoded from state; in_ready is also forced low while rst is held.
    always_comb begin
        in_ready  = !rst && (state_q != ST_DONE);
        out_valid = (state_q == ST_DONE);
        out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
        out_count = count_q;
        out_ovf   = ovf_q;
    end

endmodule
